// File: rtl/sramqsys_pio_pkg.sv
// Shared constants for the Qsys PIO blocks.
// Word address map and edge-type encodings.
package sramqsys_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sramqsys_status_in_pio_if.sv
// Avalon-MM slave bus bundle for the status input PIO.
// Master drives address/strobes, slave returns readdata and irq.
interface sramqsys_status_in_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface

// File: rtl/pio_in_sync_edge.sv
// Input synchroniser, one-cycle history and per-bit edge detect.
// data_in is the last synchroniser stage; edge_det is combinational.
module pio_in_sync_edge
    import sramqsys_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  prev_d;

    // Shift chain: stage 0 takes the raw pins, prev trails data_in.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history flops, cleared by async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign data_in = sync_q[SYNC_STAGES-1];

    // Edge selection fixed at elaboration by EDGE_TYPE.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_det = data_in & ~prev_q;
            EDGE_FALL: edge_det = ~data_in & prev_q;
            default:   edge_det = data_in ^ prev_q;
        endcase
    end

endmodule

// File: rtl/sramqsys_status_in_pio.sv
// Avalon-MM input PIO with edge capture and maskable level irq.
// Register file, registered read mux and irq; sync lives below.
module sramqsys_status_in_pio
    import sramqsys_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_port,
    sramqsys_status_in_pio_if.slave   bus
);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] edge_det;

    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q;
    logic [WIDTH-1:0] edge_cap_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] clr_bits;
    logic             unused_wd;

    pio_in_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .data_in  (data_in),
        .edge_det (edge_det)
    );

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign unused_wd = ^bus.writedata;

    // Next-state for mask and capture; a new edge beats a same-cycle clear.
    always_comb begin
        irq_mask_d = irq_mask_q;
        clr_bits   = '0;
        if (wr_en && bus.address == ADDR_IRQMASK) begin
            irq_mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == ADDR_EDGECAP) begin
            clr_bits = bus.writedata[WIDTH-1:0];
        end
        edge_cap_d = (edge_cap_q & ~clr_bits) | edge_det;
    end

    // Read mux from current register values, so a colliding write reads old data.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = data_in;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_cap_q;
            default:      readdata_d = '0;
        endcase
    end

    // Register file and one-cycle read pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_sramqsys_status_in_pio.sv
// Bench for the status input PIO: rising-edge and any-edge instances.
// Directed table and sequences plus random traffic against a model.
module tb_sramqsys_status_in_pio;
    import sramqsys_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  in_port = 8'h00;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;

    always #5 clk = ~clk;

    sramqsys_status_in_pio_if bus0 ();
    sramqsys_status_in_pio_if bus1 ();

    assign bus0.address    = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n    = write_n;
    assign bus0.writedata  = writedata;
    assign bus1.address    = address;
    assign bus1.chipselect = chipselect;
    assign bus1.write_n    = write_n;
    assign bus1.writedata  = writedata;

    sramqsys_status_in_pio #(
        .WIDTH(8), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)
    ) dut_rise (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus0)
    );

    sramqsys_status_in_pio #(
        .WIDTH(8), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus1)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins sampled each edge; the register view of a pin
    // sample is two edges old, the compare value for edges three edges old.
    logic [7:0]  hist [$];
    logic [31:0] m_rd   [2];
    logic [7:0]  m_cap  [2];
    logic [7:0]  m_mask [2];
    logic [7:0]  m_din, m_old, m_clr;
    bit          m_wr;

    function automatic logic [7:0] ref_edge(int et, logic [7:0] cur, logic [7:0] old);
        if (et == EDGE_RISE) return cur & ~old;
        if (et == EDGE_FALL) return ~cur & old;
        return cur ^ old;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist = '{8'h00, 8'h00, 8'h00};
            for (int i = 0; i < 2; i++) begin
                m_rd[i] = '0;
                m_cap[i] = '0;
                m_mask[i] = '0;
            end
        end else if (hist.size() >= 3) begin
            m_din = hist[hist.size()-2];
            m_old = hist[hist.size()-3];
            m_wr  = chipselect && !write_n;
            m_clr = (m_wr && address == 2'd3) ? writedata[7:0] : 8'h00;
            for (int i = 0; i < 2; i++) begin
                case (address)
                    2'd0: m_rd[i] = {24'h0, m_din};
                    2'd2: m_rd[i] = {24'h0, m_mask[i]};
                    2'd3: m_rd[i] = {24'h0, m_cap[i]};
                    default: m_rd[i] = '0;
                endcase
                m_cap[i] = (m_cap[i] & ~m_clr) |
                           ref_edge((i == 0) ? EDGE_RISE : EDGE_ANY, m_din, m_old);
                if (m_wr && address == 2'd2) m_mask[i] = writedata[7:0];
            end
            hist.push_back(in_port);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rd_rise", bus0.readdata, m_rd[0]);
            chk("model_rd_any", bus1.readdata, m_rd[1]);
            chk("model_irq_rise", {31'h0, bus0.irq}, {31'h0, |(m_cap[0] & m_mask[0])});
            chk("model_irq_any", {31'h0, bus1.irq}, {31'h0, |(m_cap[1] & m_mask[1])});
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(logic [1:0] a, logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic bus_rd(logic [1:0] a, output logic [31:0] d0, output logic [31:0] d1);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b1;
        @(negedge clk);
        d0 = bus0.readdata;
        d1 = bus1.readdata;
        chipselect = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [7:0]  inp;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] r0, r1;

        tbl[0]  = '{1'b1, 2'd3, 32'h01, 8'h05, 32'h0, 1'b1};
        tbl[1]  = '{1'b0, 2'd3, 32'h00, 8'h05, 32'h04, 1'b1};
        tbl[2]  = '{1'b1, 2'd3, 32'h04, 8'h05, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 2'd3, 32'h00, 8'h05, 32'h00, 1'b0};
        tbl[4]  = '{1'b1, 2'd2, 32'h04, 8'h05, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 2'd2, 32'h00, 8'h05, 32'h04, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 32'h00, 8'h00, 32'h00, 1'b0};
        tbl[7]  = '{1'b0, 2'd3, 32'h00, 8'h04, 32'h04, 1'b1};
        tbl[8]  = '{1'b1, 2'd3, 32'hFF, 8'h04, 32'h0, 1'b0};
        tbl[9]  = '{1'b0, 2'd3, 32'h00, 8'h05, 32'h01, 1'b0};
        tbl[10] = '{1'b1, 2'd0, 32'hFFFFFFFF, 8'h05, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 32'hFFFFFFFF, 8'h05, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 2'd1, 32'h00, 8'h05, 32'h00, 1'b0};
        tbl[13] = '{1'b0, 2'd2, 32'h00, 8'h05, 32'h04, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 32'h00, 8'h05, 32'h05, 1'b0};
        tbl[15] = '{1'b0, 2'd3, 32'h00, 8'h05, 32'h01, 1'b0};

        // Reset with inputs held high.
        #1 reset_n = 1'b0;
        in_port = 8'hFF;
        chk_en = 1'b1;
        idle(2);
        chk("reset_rd", bus0.readdata, 32'h0);
        chk("reset_irq", {31'h0, bus0.irq}, 32'h0);
        reset_n = 1'b1;
        idle(3);
        bus_rd(2'd0, r0, r1);
        chk("post_reset_data", r0, 32'hFF);
        bus_rd(2'd3, r0, r1);
        chk("post_reset_cap_rise", r0, 32'hFF);
        chk("post_reset_cap_any", r1, 32'hFF);

        // Latency from a pin change to data, capture and irq.
        in_port = 8'h00;
        idle(4);
        bus_wr(2'd3, 32'hFF);
        bus_wr(2'd2, 32'h05);
        address = 2'd0;
        chipselect = 1'b1;
        in_port = 8'h05;
        idle(1);
        chk("lat_k_rd", bus0.readdata, 32'h0);
        chk("lat_k_irq", {31'h0, bus0.irq}, 32'h0);
        idle(1);
        chk("lat_k1_rd", bus0.readdata, 32'h0);
        chk("lat_k1_irq", {31'h0, bus0.irq}, 32'h0);
        idle(1);
        chk("lat_k2_rd", bus0.readdata, 32'h05);
        chk("lat_k2_irq", {31'h0, bus0.irq}, 32'h1);
        chipselect = 1'b0;
        bus_rd(2'd3, r0, r1);
        chk("lat_cap", r0, 32'h05);

        // Register table: mask, W1C, ignored and reserved writes.
        for (int i = 0; i < 16; i++) begin
            in_port = tbl[i].inp;
            idle(3);
            if (tbl[i].is_wr) begin
                bus_wr(tbl[i].addr, tbl[i].wd);
            end else begin
                bus_rd(tbl[i].addr, r0, r1);
                chk($sformatf("tbl%0d_rd", i), r0, tbl[i].exp_rd);
            end
            chk($sformatf("tbl%0d_irq", i), {31'h0, bus0.irq}, {31'h0, tbl[i].exp_irq});
        end

        // Clear colliding with a new rising edge on the same bit.
        bus_wr(2'd3, 32'hFF);
        in_port = 8'h07;
        idle(2);
        address = 2'd3;
        writedata = 32'h02;
        chipselect = 1'b1;
        write_n = 1'b0;
        idle(1);
        chipselect = 1'b0;
        write_n = 1'b1;
        bus_rd(2'd3, r0, r1);
        chk("collide_rise", r0, 32'h02);
        chk("collide_any", r1, 32'h02);

        // Any-edge capture on both directions of bit 7.
        bus_wr(2'd3, 32'hFF);
        in_port = 8'h87;
        idle(3);
        bus_rd(2'd3, r0, r1);
        chk("b7_up_rise", r0, 32'h80);
        chk("b7_up_any", r1, 32'h80);
        bus_wr(2'd3, 32'hFF);
        in_port = 8'h07;
        idle(3);
        bus_rd(2'd3, r0, r1);
        chk("b7_down_rise", r0, 32'h00);
        chk("b7_down_any", r1, 32'h80);

        // Reset mid-operation with irq active and pins held high.
        bus_wr(2'd2, 32'hFF);
        in_port = 8'hFF;
        address = 2'd0;
        idle(3);
        chk("pre_rst_irq", {31'h0, bus0.irq}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_rd", bus0.readdata, 32'h0);
        chk("mid_rst_irq", {31'h0, bus0.irq}, 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(3);
        bus_rd(2'd3, r0, r1);
        chk("rst_release_cap", r0, 32'hFF);

        // Random traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            address = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n = ($urandom_range(0, 2) != 0);
            writedata = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            idle(1);
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sramqsys_status_in_pio.md
Name: sramqsys_status_in_pio

Overview:
Avalon-MM slave input PIO: the read-direction counterpart of the existing chip-select output PIO. It samples an external status bus (wireless module / button lines), synchronises it into clk, and captures edges per bit. It raises a maskable interrupt to the Nios II. It sits on the same Qsys data master as the output PIOs, with the same 2-bit word address map and a 32-bit data path.

Parameters:
WIDTH, 8, number of input bits (1..32)
EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any
SYNC_STAGES, 2, synchroniser depth on in_port (2 or 3)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  asynchronous external inputs
readdata  out  32  registered read data
irq  out  1  level interrupt request

Behaviour:
- Clocking and reset:
  - One clock, clk. reset_n is asynchronous and active-low.
  - Reset clears all of these to 0: synchroniser flops, prev-sample reg, irq_mask, edge_capture, readdata. irq is therefore 0 in reset.
- Synchroniser:
  - in_port passes through SYNC_STAGES flops; the last stage is data_in.
  - prev holds data_in delayed by one clk.
- Edge detect, combinational per bit from data_in and prev:
  - rising: data_in & ~prev
  - falling: ~data_in & prev
  - any: data_in ^ prev
- Register map, upper bits always read 0:
  - 0 DATA: read-only data_in; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQ_MASK: read/write, writedata[WIDTH-1:0].
  - 3 EDGE_CAPTURE: read, write-1-to-clear per bit.
- Write qualifier: chipselect && ~write_n. The write takes effect on that clk edge.
- edge_capture[i] next value:
  - 1 if edge[i]
  - else 0 if a write to address 3 has writedata[i]=1
  - else hold
  - Simultaneous edge and clear: set wins, so no event is lost.
- irq = |(edge_capture & irq_mask). It is combinational from registers, with no extra latency. It stays high until software clears the bit or masks it.
- Read timing:
  - readdata <= mux(address) every clk, regardless of chipselect. Read latency is 1 cycle (readLatency=1 in the _hw.tcl).
  - A read during a same-cycle write to IRQ_MASK or EDGE_CAPTURE returns the pre-write value.
- Input latency, for an in_port transition meeting setup before clk edge k, with SYNC_STAGES=2:
  - data_in changes at edge k+1.
  - edge_capture and irq assert after edge k+2.
  - readdata with address=0 shows the new value after edge k+2.
- Glitches: a pulse shorter than one clk may be missed. This is accepted; software must not rely on it.
- Reset mid-operation: all state clears immediately. The first edge after release compares against prev=0, so an input held high through reset produces a rising edge on release (EDGE_TYPE 0/2).

Decomposition:
- Shared package sramqsys_pio_pkg holds:
  - address constants: ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
- One sub-module, pio_in_sync_edge. It contains the synchroniser, the prev reg and the edge detect, is parameterised by WIDTH, SYNC_STAGES and EDGE_TYPE, and outputs data_in and edge. The top module keeps the register file, read mux and irq.

Test Plan:
- Reset: hold reset_n=0 with in_port=8'hFF -> readdata=0, irq=0. Release reset, wait 3 clk, read addr 0 -> 32'h000000FF; read addr 3 -> 32'h000000FF (EDGE_TYPE=0).
- Latency: in_port 8'h00->8'h05 before edge k -> edge_capture=8'h05 after edge k+2. Read addr 0 issued at edge k+2 -> readdata=32'h00000005 one cycle later.
- Mask: write addr 2 = 32'h04, then pulse in_port[2] 0->1 -> irq=1. Pulse in_port[0] alone with edge_capture cleared -> irq stays 0 while edge_capture[0]=1.
- W1C: edge_capture=8'h05, write addr 3 = 32'h01 -> reads 8'h04. Write 32'h04 -> reads 0 and irq falls the next cycle.
- Collision: write addr 3 = 32'h02 on the same cycle that bit 1 gets a rising edge -> edge_capture[1] remains 1.
- Ignored/reserved: write addr 0 = 32'hFFFFFFFF and addr 1 = 32'hFFFFFFFF -> no state change; addr 1 reads 0. With EDGE_TYPE=2, in_port[7] 0->1->0 -> bit 7 set by each transition.
